// File: rtl/arp_header_rewrite.sv
// ARP header rewrite stage: resolves the LPM next hop against a 32-entry ARP
// table, rewrites the first beat of each packet (dst MAC, TTL, checksum, DST
// port one-hot) or punts it to the CPU queue, and passes later beats through.
module arp_header_rewrite #(
   parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned SRC_PORT_POS         = 16,
   parameter int unsigned DST_PORT_POS         = 24
) (
   input  logic                            AXI_ACLK,
   input  logic                            AXI_RESETN,
   input  logic [255:0]                    S_AXIS_TDATA,
   input  logic [31:0]                     S_AXIS_TSTRB,
   input  logic [C_M_AXIS_TUSER_WIDTH-1:0] S_AXIS_TUSER,
   input  logic                            S_AXIS_TVALID,
   output logic                            S_AXIS_TREADY,
   input  logic                            S_AXIS_TLAST,
   output logic [255:0]                    M_AXIS_TDATA,
   output logic [31:0]                     M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0] M_AXIS_TUSER,
   output logic                            M_AXIS_TVALID,
   input  logic                            M_AXIS_TREADY,
   output logic                            M_AXIS_TLAST,
   input  logic                            lpm_hit_in,
   input  logic [31:0]                     nh_in,
   input  logic [31:0]                     oq_in,
   input  logic                            tbl_wr_req,
   input  logic [4:0]                      tbl_wr_addr,
   input  logic [127:0]                    tbl_wr_data,
   output logic                            tbl_wr_ack,
   input  logic                            tbl_rd_req,
   input  logic [4:0]                      tbl_rd_addr,
   output logic [127:0]                    tbl_rd_data,
   output logic                            tbl_rd_ack,
   output logic [31:0]                     arp_miss_count
);

   localparam int unsigned DATA_W     = 256;
   localparam int unsigned STRB_W     = 32;
   localparam int unsigned USER_W     = C_M_AXIS_TUSER_WIDTH;
   localparam int unsigned ENTRIES    = 32;
   localparam int unsigned ADDR_W     = 5;
   localparam int unsigned MAC_W      = 48;
   localparam int unsigned IP_W       = 32;
   localparam int unsigned TBL_DATA_W = 128;

   typedef enum logic [1:0] {IDLE, LOOKUP, HDR, BODY} state_t;

   state_t              state;
   state_t              state_next;

   logic [DATA_W-1:0]   beat_data;
   logic [STRB_W-1:0]   beat_strb;
   logic [USER_W-1:0]   beat_user;
   logic                beat_last;
   logic                lpm_hit;
   logic [IP_W-1:0]     nh;
   logic [31:0]         oq;
   logic                tready_en;

   logic [ENTRIES-1:0]  tbl_valid;
   logic [MAC_W-1:0]    tbl_mac [ENTRIES];
   logic [IP_W-1:0]     tbl_ip  [ENTRIES];

   logic                arp_hit_c;
   logic [MAC_W-1:0]    arp_mac_c;
   logic [7:0]          ttl_c;
   logic [16:0]         csum_sum_c;
   logic [7:0]          src_c;
   logic [7:0]          dst_c;
   logic                cpu_bound_c;
   logic                forward_c;
   logic [DATA_W-1:0]   hdr_data_c;
   logic [USER_W-1:0]   hdr_user_c;

   logic                unused_wr_bits;
   assign unused_wr_bits = ^tbl_wr_data[127:81];

   // State register
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) state <= IDLE;
      else             state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (S_AXIS_TVALID && tready_en) state_next = LOOKUP;
         LOOKUP:  state_next = HDR;
         HDR:     if (M_AXIS_TREADY) state_next = beat_last ? IDLE : BODY;
         BODY:    if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Stream outputs: held header beat in HDR, straight pass-through in BODY
   always_comb begin
      S_AXIS_TREADY = 1'b0;
      M_AXIS_TVALID = 1'b0;
      M_AXIS_TDATA  = '0;
      M_AXIS_TSTRB  = '0;
      M_AXIS_TUSER  = '0;
      M_AXIS_TLAST  = 1'b0;
      case (state)
         IDLE: S_AXIS_TREADY = tready_en;
         HDR: begin
            M_AXIS_TVALID = 1'b1;
            M_AXIS_TDATA  = beat_data;
            M_AXIS_TSTRB  = beat_strb;
            M_AXIS_TUSER  = beat_user;
            M_AXIS_TLAST  = beat_last;
         end
         BODY: begin
            S_AXIS_TREADY = M_AXIS_TREADY;
            M_AXIS_TVALID = S_AXIS_TVALID;
            M_AXIS_TDATA  = S_AXIS_TDATA;
            M_AXIS_TSTRB  = S_AXIS_TSTRB;
            M_AXIS_TUSER  = S_AXIS_TUSER;
            M_AXIS_TLAST  = S_AXIS_TLAST;
         end
         default: ;
      endcase
   end

   // Parallel ARP match; scanning downward lets the lowest index win
   always_comb begin
      arp_hit_c = 1'b0;
      arp_mac_c = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (tbl_valid[ADDR_W'(i)] && (tbl_ip[ADDR_W'(i)] == nh)) begin
            arp_hit_c = 1'b1;
            arp_mac_c = tbl_mac[ADDR_W'(i)];
         end
      end
   end

   // Header rewrite decision: forward, punt to CPU queue, or leave untouched
   always_comb begin
      ttl_c       = beat_data[79:72];
      csum_sum_c  = {1'b0, beat_data[63:48]} + 17'h00100;
      src_c       = beat_user[SRC_PORT_POS +: 8];
      dst_c       = beat_user[DST_PORT_POS +: 8];
      cpu_bound_c = |(dst_c & 8'hAA);
      forward_c   = lpm_hit && arp_hit_c && (ttl_c > 8'd1) && (oq[31:2] == 30'd0);
      hdr_data_c  = beat_data;
      hdr_user_c  = beat_user;
      if (!cpu_bound_c) begin
         if (forward_c) begin
            hdr_data_c[255:208]            = arp_mac_c;
            hdr_data_c[79:72]              = ttl_c - 8'd1;
            hdr_data_c[63:48]              = csum_sum_c[15:0] + 16'(csum_sum_c[16]);
            hdr_user_c[DST_PORT_POS +: 8]  = 8'(8'h01 << {oq[1:0], 1'b0});
         end else begin
            hdr_user_c[DST_PORT_POS +: 8]  = 8'((src_c & 8'h55) << 1);
         end
      end
   end

   // First-beat capture, in-place header rewrite and ARP miss counting
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         beat_data      <= '0;
         beat_strb      <= '0;
         beat_user      <= '0;
         beat_last      <= 1'b0;
         lpm_hit        <= 1'b0;
         nh             <= '0;
         oq             <= '0;
         tready_en      <= 1'b0;
         arp_miss_count <= '0;
      end else begin
         tready_en <= 1'b1;
         if ((state == IDLE) && S_AXIS_TVALID && tready_en) begin
            beat_data <= S_AXIS_TDATA;
            beat_strb <= S_AXIS_TSTRB;
            beat_user <= S_AXIS_TUSER;
            beat_last <= S_AXIS_TLAST;
            lpm_hit   <= lpm_hit_in;
            nh        <= nh_in;
            oq        <= oq_in;
         end
         if (state == LOOKUP) begin
            beat_data <= hdr_data_c;
            beat_user <= hdr_user_c;
            if (lpm_hit && !arp_hit_c) arp_miss_count <= arp_miss_count + 32'd1;
         end
      end
   end

   // ARP table storage with registered write/read acknowledge
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         tbl_valid   <= '0;
         tbl_wr_ack  <= 1'b0;
         tbl_rd_ack  <= 1'b0;
         tbl_rd_data <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) begin
            tbl_mac[ADDR_W'(i)] <= '0;
            tbl_ip[ADDR_W'(i)]  <= '0;
         end
      end else begin
         tbl_wr_ack <= tbl_wr_req;
         tbl_rd_ack <= tbl_rd_req;
         if (tbl_rd_req) begin
            tbl_rd_data <= TBL_DATA_W'({tbl_valid[tbl_rd_addr], tbl_mac[tbl_rd_addr],
                                        tbl_ip[tbl_rd_addr]});
         end
         if (tbl_wr_req) begin
            tbl_valid[tbl_wr_addr] <= tbl_wr_data[80];
            tbl_mac[tbl_wr_addr]   <= tbl_wr_data[79:32];
            tbl_ip[tbl_wr_addr]    <= tbl_wr_data[31:0];
         end
      end
   end

endmodule

// File: tb/tb_arp_header_rewrite.sv
// Directed bench for arp_header_rewrite: forward/punt/pass-through header
// rewrites, checksum wrap, back-pressure, table access and mid-packet reset.
module tb_arp_header_rewrite;

   logic          AXI_ACLK = 1'b0;
   logic          AXI_RESETN;
   logic [255:0]  S_AXIS_TDATA;
   logic [31:0]   S_AXIS_TSTRB;
   logic [127:0]  S_AXIS_TUSER;
   logic          S_AXIS_TVALID;
   logic          S_AXIS_TREADY;
   logic          S_AXIS_TLAST;
   logic [255:0]  M_AXIS_TDATA;
   logic [31:0]   M_AXIS_TSTRB;
   logic [127:0]  M_AXIS_TUSER;
   logic          M_AXIS_TVALID;
   logic          M_AXIS_TREADY;
   logic          M_AXIS_TLAST;
   logic          lpm_hit_in;
   logic [31:0]   nh_in;
   logic [31:0]   oq_in;
   logic          tbl_wr_req;
   logic [4:0]    tbl_wr_addr;
   logic [127:0]  tbl_wr_data;
   logic          tbl_wr_ack;
   logic          tbl_rd_req;
   logic [4:0]    tbl_rd_addr;
   logic [127:0]  tbl_rd_data;
   logic          tbl_rd_ack;
   logic [31:0]   arp_miss_count;

   int checks = 0;
   int errors = 0;

   localparam logic [47:0] MAC_IN = 48'h112233445566;
   localparam logic [47:0] MAC3   = 48'h0A0B0C0D0E0F;
   localparam logic [31:0] IP_NH  = 32'h0A000002;

   arp_header_rewrite #(
      .C_M_AXIS_TUSER_WIDTH(128),
      .SRC_PORT_POS(16),
      .DST_PORT_POS(24)
   ) dut (
      .AXI_ACLK(AXI_ACLK), .AXI_RESETN(AXI_RESETN),
      .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
      .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TVALID(S_AXIS_TVALID),
      .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
      .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TVALID(M_AXIS_TVALID),
      .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
      .lpm_hit_in(lpm_hit_in), .nh_in(nh_in), .oq_in(oq_in),
      .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
      .tbl_wr_ack(tbl_wr_ack),
      .tbl_rd_req(tbl_rd_req), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
      .tbl_rd_ack(tbl_rd_ack),
      .arp_miss_count(arp_miss_count)
   );

   always #5 AXI_ACLK = ~AXI_ACLK;

   task automatic tick();
      @(posedge AXI_ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Header beat with the given dst MAC, TTL and checksum over a fixed filler
   function automatic logic [255:0] mk(input logic [47:0] mac, input logic [7:0] ttl,
                                       input logic [15:0] cs);
      logic [255:0] r;
      r = {8{32'hDEADBEEF}};
      r[255:208] = mac;
      r[79:72]   = ttl;
      r[63:48]   = cs;
      return r;
   endfunction

   // TUSER with length 64, given src/dst one-hots and a marker in the top word
   function automatic logic [127:0] mku(input logic [7:0] src, input logic [7:0] dst);
      logic [127:0] r;
      r = '0;
      r[15:0]   = 16'd64;
      r[23:16]  = src;
      r[31:24]  = dst;
      r[127:96] = 32'hCAFEF00D;
      return r;
   endfunction

   task automatic tbl_write(input logic [4:0] addr, input logic [127:0] data);
      tbl_wr_req  = 1'b1;
      tbl_wr_addr = addr;
      tbl_wr_data = data;
      tick();
      tbl_wr_req  = 1'b0;
      check("wr_ack", 256'(tbl_wr_ack), 256'(1));
   endtask

   // Present a first beat, wait for acceptance, then step through LOOKUP into HDR
   task automatic send_first(input logic [255:0] d, input logic [127:0] u, input logic last,
                             input logic lpm, input logic [31:0] nh, input logic [31:0] oq);
      int n;
      S_AXIS_TDATA  = d;
      S_AXIS_TSTRB  = 32'hFFFFFFFF;
      S_AXIS_TUSER  = u;
      S_AXIS_TLAST  = last;
      S_AXIS_TVALID = 1'b1;
      lpm_hit_in    = lpm;
      nh_in         = nh;
      oq_in         = oq;
      n = 0;
      while (!S_AXIS_TREADY && n < 20) begin
         tick();
         n++;
      end
      check("first_ready", 256'(S_AXIS_TREADY), 256'(1));
      tick();
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      S_AXIS_TDATA  = '0;
      S_AXIS_TUSER  = '0;
      lpm_hit_in    = 1'b0;
      nh_in         = '0;
      oq_in         = '0;
      check("lookup_bubble", 256'(S_AXIS_TREADY), 256'(0));
      tick();
   endtask

   task automatic run_single(input string tag, input logic [255:0] d, input logic [127:0] u,
                             input logic lpm, input logic [31:0] nh, input logic [31:0] oq,
                             input logic [255:0] ed, input logic [127:0] eu);
      send_first(d, u, 1'b1, lpm, nh, oq);
      check({tag, "_valid"}, 256'(M_AXIS_TVALID), 256'(1));
      check({tag, "_data"},  M_AXIS_TDATA, ed);
      check({tag, "_user"},  256'(M_AXIS_TUSER), 256'(eu));
      check({tag, "_last"},  256'(M_AXIS_TLAST), 256'(1));
      tick();
      check({tag, "_idle"},  256'(M_AXIS_TVALID), 256'(0));
   endtask

   initial begin
      AXI_RESETN    = 1'b0;
      S_AXIS_TDATA  = '0;
      S_AXIS_TSTRB  = '0;
      S_AXIS_TUSER  = '0;
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      M_AXIS_TREADY = 1'b1;
      lpm_hit_in    = 1'b0;
      nh_in         = '0;
      oq_in         = '0;
      tbl_wr_req    = 1'b0;
      tbl_wr_addr   = '0;
      tbl_wr_data   = '0;
      tbl_rd_req    = 1'b0;
      tbl_rd_addr   = '0;
      #1;
      check("rst_s_tready", 256'(S_AXIS_TREADY), 256'(0));
      check("rst_m_tvalid", 256'(M_AXIS_TVALID), 256'(0));
      check("rst_miss",     256'(arp_miss_count), 256'(0));
      check("rst_rd_data",  256'(tbl_rd_data), 256'(0));
      check("rst_acks",     256'({tbl_wr_ack, tbl_rd_ack}), 256'(0));
      tick(); tick();
      AXI_RESETN = 1'b1;
      tick();

      // Entry 1 invalid and entry 9 valid with the same IP: entry 3 must win
      tbl_write(5'd1, {47'd0, 1'b0, 48'h999999999999, IP_NH});
      tbl_write(5'd3, {47'd0, 1'b1, MAC3, IP_NH});
      tbl_write(5'd9, {47'd0, 1'b1, 48'h777777777777, IP_NH});

      // Two-beat forward, oq 1: TTL 40->3F, checksum B1E6->B2E6, DST 0x04
      send_first(mk(MAC_IN, 8'h40, 16'hB1E6), mku(8'h01, 8'h00), 1'b0, 1'b1, IP_NH, 32'd1);
      check("fwd_valid", 256'(M_AXIS_TVALID), 256'(1));
      check("fwd_data",  M_AXIS_TDATA, mk(MAC3, 8'h3F, 16'hB2E6));
      check("fwd_user",  256'(M_AXIS_TUSER), 256'(mku(8'h01, 8'h04)));
      check("fwd_last",  256'(M_AXIS_TLAST), 256'(0));
      check("fwd_strb",  256'(M_AXIS_TSTRB), 256'(32'hFFFFFFFF));
      S_AXIS_TDATA  = {8{32'h0BAD0BAD}};
      S_AXIS_TUSER  = 128'h5555_0000_0000_0000_0000_0000_8844_0020;
      S_AXIS_TSTRB  = 32'h0000FFFF;
      S_AXIS_TLAST  = 1'b1;
      S_AXIS_TVALID = 1'b1;
      tick();
      check("body_valid", 256'(M_AXIS_TVALID), 256'(1));
      check("body_data",  M_AXIS_TDATA, {8{32'h0BAD0BAD}});
      check("body_user",  256'(M_AXIS_TUSER), 256'(128'h5555_0000_0000_0000_0000_0000_8844_0020));
      check("body_last",  256'(M_AXIS_TLAST), 256'(1));
      check("body_ready", 256'(S_AXIS_TREADY), 256'(1));
      tick();
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      check("body_to_idle", 256'(S_AXIS_TREADY), 256'(1));

      // Checksum end-around carry: FF00 -> 0001, TTL 20 -> 1F, oq 0 -> DST 0x01
      run_single("csum_wrap", mk(MAC_IN, 8'h20, 16'hFF00), mku(8'h04, 8'h00), 1'b1, IP_NH, 32'd0,
                 mk(MAC3, 8'h1F, 16'h0001), mku(8'h04, 8'h01));

      // ARP miss: punt src 0x10 -> DST 0x20, data untouched, counter 0 -> 1
      check("miss_before", 256'(arp_miss_count), 256'(0));
      run_single("arp_miss", mk(MAC_IN, 8'h40, 16'h1234), mku(8'h10, 8'h00), 1'b1, 32'h0A000063,
                 32'd2, mk(MAC_IN, 8'h40, 16'h1234), mku(8'h10, 8'h20));
      check("miss_after", 256'(arp_miss_count), 256'(1));

      // Back-pressure for 5 cycles on a TTL=1 punt (src 0x04 -> DST 0x08)
      M_AXIS_TREADY = 1'b0;
      send_first(mk(MAC_IN, 8'h01, 16'h4321), mku(8'h04, 8'h00), 1'b1, 1'b1, IP_NH, 32'd3);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 256'(M_AXIS_TVALID), 256'(1));
         check("stall_data",  M_AXIS_TDATA, mk(MAC_IN, 8'h01, 16'h4321));
         check("stall_user",  256'(M_AXIS_TUSER), 256'(mku(8'h04, 8'h08)));
         check("stall_last",  256'(M_AXIS_TLAST), 256'(1));
         tick();
      end
      M_AXIS_TREADY = 1'b1;
      tick();
      check("stall_idle_valid", 256'(M_AXIS_TVALID), 256'(0));
      check("stall_idle_ready", 256'(S_AXIS_TREADY), 256'(1));

      // oq out of range punts (src 0x40 -> DST 0x80); ARP hit so no miss count
      run_single("oq_range", mk(MAC_IN, 8'h40, 16'h1000), mku(8'h40, 8'h00), 1'b1, IP_NH, 32'd4,
                 mk(MAC_IN, 8'h40, 16'h1000), mku(8'h40, 8'h80));
      check("oq_range_miss", 256'(arp_miss_count), 256'(1));

      // Preset CPU-bound DST bit: packet passes completely unmodified
      run_single("cpu_bound", mk(MAC_IN, 8'h40, 16'h2000), mku(8'h01, 8'h02), 1'b1, IP_NH, 32'd1,
                 mk(MAC_IN, 8'h40, 16'h2000), mku(8'h01, 8'h02));

      // LPM miss punts even with a matching next hop; not an ARP miss
      run_single("lpm_miss", mk(MAC_IN, 8'h40, 16'h3000), mku(8'h01, 8'h00), 1'b0, IP_NH, 32'd1,
                 mk(MAC_IN, 8'h40, 16'h3000), mku(8'h01, 8'h02));
      check("lpm_miss_count", 256'(arp_miss_count), 256'(1));

      // TTL 2 still forwards; oq 3 -> DST 0x40; checksum 0000 -> 0100
      run_single("ttl2_oq3", mk(MAC_IN, 8'h02, 16'h0000), mku(8'h01, 8'h00), 1'b1, IP_NH, 32'd3,
                 mk(MAC3, 8'h01, 16'h0100), mku(8'h01, 8'h40));

      // Table: write 7, then read 7 in the same cycle as a second write to 7
      tbl_write(5'd7, {47'h1FFF_FFFF_FFFF, 1'b1, 48'hA1A2A3A4A5A6, 32'hC0A80001});
      tbl_rd_req  = 1'b1;
      tbl_rd_addr = 5'd7;
      tbl_wr_req  = 1'b1;
      tbl_wr_addr = 5'd7;
      tbl_wr_data = {47'd0, 1'b0, 48'hB1B2B3B4B5B6, 32'hC0A80002};
      tick();
      tbl_rd_req = 1'b0;
      tbl_wr_req = 1'b0;
      check("rd_ack",      256'(tbl_rd_ack), 256'(1));
      check("rd_wr_ack",   256'(tbl_wr_ack), 256'(1));
      check("rd_old_data", 256'(tbl_rd_data),
            256'({47'd0, 1'b1, 48'hA1A2A3A4A5A6, 32'hC0A80001}));
      tick();
      check("acks_drop", 256'({tbl_wr_ack, tbl_rd_ack}), 256'(0));
      tbl_rd_req = 1'b1;
      tick();
      tbl_rd_req = 1'b0;
      check("rd_new_data", 256'(tbl_rd_data),
            256'({47'd0, 1'b0, 48'hB1B2B3B4B5B6, 32'hC0A80002}));

      // Reset in the middle of BODY
      send_first(mk(MAC_IN, 8'h40, 16'hB1E6), mku(8'h01, 8'h00), 1'b0, 1'b1, IP_NH, 32'd1);
      check("pre_rst_hdr", M_AXIS_TDATA, mk(MAC3, 8'h3F, 16'hB2E6));
      S_AXIS_TDATA  = {8{32'h0BAD0BAD}};
      S_AXIS_TUSER  = 128'h0;
      S_AXIS_TLAST  = 1'b0;
      S_AXIS_TVALID = 1'b1;
      tick();
      check("pre_rst_body", 256'(M_AXIS_TVALID), 256'(1));
      #2;
      AXI_RESETN = 1'b0;
      #1;
      check("rst_mid_m_tvalid", 256'(M_AXIS_TVALID), 256'(0));
      check("rst_mid_s_tready", 256'(S_AXIS_TREADY), 256'(0));
      check("rst_mid_miss",     256'(arp_miss_count), 256'(0));
      check("rst_mid_rd_data",  256'(tbl_rd_data), 256'(0));
      S_AXIS_TVALID = 1'b0;
      tick(); tick();
      AXI_RESETN = 1'b1;
      tbl_rd_req  = 1'b1;
      tbl_rd_addr = 5'd3;
      tick();
      tbl_rd_req = 1'b0;
      check("post_rst_rd_ack",  256'(tbl_rd_ack), 256'(1));
      check("post_rst_rd_data", 256'(tbl_rd_data), 256'(0));

      // Normal forwarding after reset, oq 2 -> DST 0x10
      tbl_write(5'd3, {47'd0, 1'b1, MAC3, IP_NH});
      run_single("post_rst", mk(MAC_IN, 8'h40, 16'h1234), mku(8'h01, 8'h00), 1'b1, IP_NH, 32'd2,
                 mk(MAC3, 8'h3F, 16'h1334), mku(8'h01, 8'h10));
      check("post_rst_miss", 256'(arp_miss_count), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arp_header_rewrite.md
ARP_HEADER_REWRITE -- requirements
Module: arp_header_rewrite

Interface
REQ-001 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, TUSER width of both streams.
REQ-002 SHALL have parameter SRC_PORT_POS, default 16, LSB of the 8-bit source-port one-hot in TUSER.
REQ-003 SHALL have parameter DST_PORT_POS, default 24, LSB of the 8-bit destination-port one-hot in TUSER.
REQ-004 SHALL fix TDATA width at 256 and TSTRB width at 32.
REQ-005 AXI_ACLK  in  1  sole clock, rising edge.
REQ-006 AXI_RESETN  in  1  reset, asynchronous, active-low.
REQ-007 S_AXIS_TDATA  in  256  packet data from the LPM stage.
REQ-008 S_AXIS_TSTRB  in  32  byte strobes.
REQ-009 S_AXIS_TUSER  in  C_M_AXIS_TUSER_WIDTH  sideband (length, src/dst port).
REQ-010 S_AXIS_TVALID  in  1  beat valid.
REQ-011 S_AXIS_TREADY  out  1  beat accepted.
REQ-012 S_AXIS_TLAST  in  1  last beat.
REQ-013 M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/C_M_AXIS_TUSER_WIDTH/1/1  rewritten stream.
REQ-014 M_AXIS_TREADY  in  1  downstream ready.
REQ-015 lpm_hit_in  in  1  LPM result valid for the current packet.
REQ-016 nh_in  in  32  next-hop IPv4 address.
REQ-017 oq_in  in  32  output-queue index (0-3 valid).
REQ-018 tbl_wr_req  in  1  one-cycle ARP-table write request.
REQ-019 tbl_wr_addr  in  5  write entry index.
REQ-020 tbl_wr_data  in  128  [80] valid, [79:32] MAC, [31:0] IP; [127:81] ignored.
REQ-021 tbl_wr_ack  out  1  one-cycle write acknowledge.
REQ-022 tbl_rd_req  in  1  one-cycle read request.
REQ-023 tbl_rd_addr  in  5  read entry index.
REQ-024 tbl_rd_data  out  128  {47'b0, entry[80:0]}.
REQ-025 tbl_rd_ack  out  1  one-cycle read acknowledge.
REQ-026 arp_miss_count  out  32  count of LPM-hit packets with no ARP match.

Function
REQ-027 SHALL implement states IDLE, LOOKUP, HDR, BODY.
REQ-028 IDLE: S_AXIS_TREADY=1; on first beat accepted, register beat, lpm_hit_in, nh_in, oq_in; go LOOKUP.
REQ-029 LOOKUP (exactly 1 cycle): S_AXIS_TREADY=0; compare nh against all 32 valid entries in parallel; lowest matching index wins; register decision; go HDR.
REQ-030 HDR: M_AXIS_TVALID=1 with rewritten header beat, held stable until M_AXIS_TREADY; then BODY, or IDLE if beat had TLAST.
REQ-031 BODY: M_AXIS_TVALID=S_AXIS_TVALID, S_AXIS_TREADY=M_AXIS_TREADY, data passes unregistered; IDLE after TLAST handshake.
REQ-032 Forward rewrite (lpm hit, ARP hit, TTL [79:72] > 1, no odd DST bit preset): TDATA[255:208]=entry MAC; TTL-1; checksum [63:48] += 0x0100 with ones'-complement end-around carry; DST one-hot = 0x01/0x04/0x10/0x40 for oq 0/1/2/3.
REQ-033 Punt (lpm miss, ARP miss, TTL<=1, or oq>3): TDATA unchanged; DST one-hot = source bit 2k moved to bit 2k+1 (CPU queue).
REQ-034 Preset odd DST bit (CPU-bound): packet passes entirely unmodified.
REQ-035 arp_miss_count SHALL increment by 1 per packet with lpm hit and ARP miss, wrapping 0xFFFFFFFF->0.
REQ-036 Table write: entry updated and tbl_wr_ack=1 on the cycle after tbl_wr_req; a write during LOOKUP is not seen by that lookup.
REQ-037 Table read: tbl_rd_data valid with tbl_rd_ack=1 the cycle after tbl_rd_req; same-cycle read and write to one index returns pre-write value.
REQ-038 Non-first-beat TUSER SHALL pass unchanged.

Reset
REQ-039 AXI_RESETN low SHALL asynchronously force IDLE, all table valid bits 0, arp_miss_count=0, tbl_rd_data=0, acks=0, M_AXIS_TVALID=0, S_AXIS_TREADY=0 while asserted.
REQ-040 Reset mid-packet SHALL discard the packet; after release the next beat seen is treated as a first beat.

Verification
REQ-041 Entry 3={1,MAC 0x0A0B0C0D0E0F,IP 10.0.0.2}; 2-beat packet, src port 0x01, nh 10.0.0.2, oq 1, TTL 0x40, checksum 0xB1E6 -> dst MAC 0x0A0B0C0D0E0F, TTL 0x3F, checksum 0xB2E6, DST 0x04, one-cycle bubble.
REQ-042 Checksum 0xFF00, TTL 0x20, ARP hit -> checksum 0x0001, TTL 0x1F.
REQ-043 lpm_hit_in=1, nh unmatched, src 0x10 -> DST 0x20, data unchanged, arp_miss_count 0->1.
REQ-044 Single-beat packet with M_AXIS_TREADY low 5 cycles -> beat held stable, TLAST=1, returns to IDLE after handshake.
REQ-045 Write index 7 then read index 7 same cycle as a second write -> first read returns first data; acks one cycle each.
REQ-046 Assert AXI_RESETN low during BODY -> outputs reset immediately; table reads return 0; next packet processed normally.
